hiscore_dump: RTL and testbench



---
 rtl/hiscore_dump_if.sv | 47 ++++
 rtl/hiscore_dump.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_hiscore_dump.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hiscore_dump_if.sv
// ----------------------------------------------------------------------------
// hiscore_dump_if
//   The HPS ioctl transfer bus. The restore block and hiscore_dump both
//   sit on it.
//
//   Signals:
//     ioctl_download  HPS download active
//     ioctl_upload    HPS upload active
//     ioctl_wr        download byte strobe
//     ioctl_addr      byte address (25 bits)
//     ioctl_dout      download data, HPS -> core
//     ioctl_index     download index (3 = high-score address table)
//     ioctl_din       upload data, core -> HPS
//
//   Modports:
//     master  HPS side (drives the strobes, address and data; reads ioctl_din)
//     slave   core side (reads the strobes; drives ioctl_din)
// ----------------------------------------------------------------------------
interface hiscore_dump_if;
    logic        ioctl_download;
    logic        ioctl_upload;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic [7:0]  ioctl_din;

    modport master (
        output ioctl_download,
        output ioctl_upload,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_dout,
        output ioctl_index,
        input  ioctl_din
    );

    modport slave (
        input  ioctl_download,
        input  ioctl_upload,
        input  ioctl_wr,
        input  ioctl_addr,
        input  ioctl_dout,
        input  ioctl_index,
        output ioctl_din
    );
endinterface

// File: rtl/hiscore_dump.sv
// ----------------------------------------------------------------------------
// hiscore_dump
//   The save side of the high-score path. When snap_req arrives, it walks the
//   high-score address table and copies each listed game-RAM region into a
//   local byte buffer. It then serves that buffer to the HPS over the ioctl
//   upload channel.
//
//   Parameters:
//     ENTRIES  max table records (power of two); record = ioctl_addr[6:3]
//     BUF_AW   buffer address width, capacity 2**BUF_AW bytes
//     RAM_AW   game RAM address width
//
//   Ports:
//     clk, reset     single clock; synchronous active-high reset
//     ioctl          hiscore_dump_if.slave (shared ioctl bus; drives ioctl_din)
//     snap_req       single-cycle capture request
//     ram_address    game RAM read address
//     ram_rd         high while ram_address is a live capture read
//     ram_data       game RAM read data, one cycle after the address
//     busy           capture in progress
//     snap_valid     buffer holds a complete capture
//     dump_size      number of bytes captured
//     ovf            last capture exceeded buffer capacity
//     changed        last capture differs from the previous one
//
//   Build option:
//     HISCORE_DUMP_CHANGE_DETECT_EN
//       When defined, each captured byte is compared against the byte it
//       overwrites, and 'changed' reflects a real difference. When undefined,
//       'changed' is set at every completed capture.
// ----------------------------------------------------------------------------
module hiscore_dump #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned BUF_AW  = 8,
    parameter int unsigned RAM_AW  = 10
) (
    input  logic              clk,
    input  logic              reset,
    hiscore_dump_if.slave     ioctl,
    input  logic              snap_req,
    output logic [RAM_AW-1:0] ram_address,
    output logic              ram_rd,
    input  logic [7:0]        ram_data,
    output logic              busy,
    output logic              snap_valid,
    output logic [BUF_AW:0]   dump_size,
    output logic              ovf,
    output logic              changed
);

    localparam int unsigned EW  = $clog2(ENTRIES);
    localparam int unsigned PW  = BUF_AW + 1;
    localparam int unsigned CAP = 1 << BUF_AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ADDR,
        S_CAPT,
        S_DONE
    } state_t;

    // ---------------------------------------------------------------- table
    logic [23:0]   tbl_base_q [ENTRIES];
    logic [7:0]    tbl_len_q  [ENTRIES];
    logic          tbl_loaded_q;
    logic [EW-1:0] last_entry_q;

    logic          tbl_sel;
    logic          tbl_wr;
    logic [EW-1:0] wr_entry;

    assign tbl_sel  = ioctl.ioctl_download && (ioctl.ioctl_index == 8'd3);
    assign tbl_wr   = tbl_sel && ioctl.ioctl_wr;
    assign wr_entry = ioctl.ioctl_addr[EW+2:3];

    // Table contents carry no reset. They are only used once tbl_loaded_q is set.
    always_ff @(posedge clk) begin
        if (tbl_wr) begin
            unique case (ioctl.ioctl_addr[2:0])
                3'd1:    tbl_base_q[wr_entry][23:16] <= ioctl.ioctl_dout;
                3'd2:    tbl_base_q[wr_entry][15:8]  <= ioctl.ioctl_dout;
                3'd3:    tbl_base_q[wr_entry][7:0]   <= ioctl.ioctl_dout;
                3'd4:    tbl_len_q[wr_entry]         <= ioctl.ioctl_dout;
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- FSM
    state_t            state_q;
    logic [EW-1:0]     entry_q;
    logic [23:0]       cur_base_q;
    logic [7:0]        cur_len_q;
    logic [7:0]        off_q;
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     dump_size_q;
    logic [RAM_AW-1:0] ram_address_q;
    logic              ram_rd_q;
    logic              busy_q;
    logic              snap_valid_q;
    logic              ovf_q;
    logic              changed_q;
    logic [7:0]        din_q;

    logic [7:0] off_inc;
    logic       buf_room;

    assign off_inc  = off_q + 8'd1;
    assign buf_room = !wptr_q[BUF_AW];

`ifdef HISCORE_DUMP_CHANGE_DETECT_EN
    logic       diff_q;
    logic       first_q;
    logic [7:0] old_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            entry_q       <= '0;
            cur_base_q    <= '0;
            cur_len_q     <= '0;
            off_q         <= '0;
            wptr_q        <= '0;
            dump_size_q   <= '0;
            ram_address_q <= '0;
            ram_rd_q      <= 1'b0;
            busy_q        <= 1'b0;
            snap_valid_q  <= 1'b0;
            ovf_q         <= 1'b0;
            changed_q     <= 1'b0;
            tbl_loaded_q  <= 1'b0;
            last_entry_q  <= '0;
`ifdef HISCORE_DUMP_CHANGE_DETECT_EN
            diff_q        <= 1'b0;
            first_q       <= 1'b1;
`endif
        end else begin
            if (tbl_wr) begin
                last_entry_q <= wr_entry;
                tbl_loaded_q <= 1'b1;
            end

            if (tbl_sel) begin
                // A new table invalidates any capture in flight.
                state_q      <= S_IDLE;
                busy_q       <= 1'b0;
                snap_valid_q <= 1'b0;
                ram_rd_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        ram_rd_q <= 1'b0;
                        if (snap_req && tbl_loaded_q &&
                            !ioctl.ioctl_upload && !ioctl.ioctl_download) begin
                            state_q      <= S_SETUP;
                            busy_q       <= 1'b1;
                            entry_q      <= '0;
                            wptr_q       <= '0;
                            ovf_q        <= 1'b0;
                            snap_valid_q <= 1'b0;
                            changed_q    <= 1'b0;
`ifdef HISCORE_DUMP_CHANGE_DETECT_EN
                            diff_q       <= 1'b0;
`endif
                        end
                    end

                    S_SETUP: begin
                        cur_base_q <= tbl_base_q[entry_q];
                        cur_len_q  <= tbl_len_q[entry_q];
                        off_q      <= '0;
                        if (tbl_len_q[entry_q] == 8'd0) begin
                            if (entry_q == last_entry_q) begin
                                state_q <= S_DONE;
                            end else begin
                                entry_q <= entry_q + EW'(1);
                            end
                        end else begin
                            // Offset is 0 here, so the table base is the address.
                            ram_address_q <= RAM_AW'(tbl_base_q[entry_q]);
                            ram_rd_q      <= 1'b1;
                            state_q       <= S_ADDR;
                        end
                    end

                    S_ADDR: begin
                        ram_rd_q <= 1'b0;
                        state_q  <= S_CAPT;
                    end

                    S_CAPT: begin
                        if (buf_room) begin
                            wptr_q <= wptr_q + PW'(1);
`ifdef HISCORE_DUMP_CHANGE_DETECT_EN
                            if (old_q != ram_data) begin
                                diff_q <= 1'b1;
                            end
`endif
                        end else begin
                            ovf_q <= 1'b1;
                        end
                        off_q <= off_inc;
                        if (off_q == cur_len_q - 8'd1) begin
                            if (entry_q < last_entry_q) begin
                                entry_q <= entry_q + EW'(1);
                                state_q <= S_SETUP;
                            end else begin
                                state_q <= S_DONE;
                            end
                        end else begin
                            ram_address_q <= RAM_AW'(cur_base_q + {16'd0, off_inc});
                            ram_rd_q      <= 1'b1;
                            state_q       <= S_ADDR;
                        end
                    end

                    S_DONE: begin
                        dump_size_q  <= wptr_q;
                        snap_valid_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
`ifdef HISCORE_DUMP_CHANGE_DETECT_EN
                        changed_q    <= diff_q || first_q || (wptr_q != dump_size_q);
                        first_q      <= 1'b0;
`else
                        changed_q    <= 1'b1;
`endif
                    end

                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- buffer
    logic [7:0] buf_mem [CAP];
    logic       buf_we;

    assign buf_we = (state_q == S_CAPT) && buf_room;

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[wptr_q[BUF_AW-1:0]] <= ram_data;
        end
    end

`ifdef HISCORE_DUMP_CHANGE_DETECT_EN
    // Fetch the byte about to be overwritten. It is compared in the CAPT cycle.
    always_ff @(posedge clk) begin
        if (state_q == S_ADDR) begin
            old_q <= buf_mem[wptr_q[BUF_AW-1:0]];
        end
    end
`endif

    // Upload read port. Bytes past the captured length, and any read made
    // without a valid capture, return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            din_q <= '0;
        end else if (ioctl.ioctl_upload && snap_valid_q &&
                     (ioctl.ioctl_addr < {{(25-PW){1'b0}}, dump_size_q})) begin
            din_q <= buf_mem[ioctl.ioctl_addr[BUF_AW-1:0]];
        end else begin
            din_q <= '0;
        end
    end

    assign ioctl.ioctl_din = din_q;
    assign ram_address     = ram_address_q;
    assign ram_rd          = ram_rd_q;
    assign busy            = busy_q;
    assign snap_valid      = snap_valid_q;
    assign dump_size       = dump_size_q;
    assign ovf             = ovf_q;
    assign changed         = changed_q;

endmodule

// File: tb/tb_hiscore_dump.sv
// ----------------------------------------------------------------------------
// tb_hiscore_dump
//   Self-checking bench for hiscore_dump with BUF_AW=7, so the buffer holds
//   128 bytes. A reference model works from the table contents alone. It
//   lists the RAM bytes that should be captured, limits them to the buffer
//   capacity, computes the cycle cost, and works out the 'changed' result.
//   The bench then compares the DUT outputs and the uploaded data against
//   that model.
// ----------------------------------------------------------------------------
module tb_hiscore_dump;

    localparam int unsigned BUF_AW = 7;
    localparam int unsigned RAM_AW = 10;
    localparam int unsigned CAP    = 1 << BUF_AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              snap_req;
    logic [RAM_AW-1:0] ram_address;
    logic              ram_rd;
    logic [7:0]        ram_data;
    logic              busy;
    logic              snap_valid;
    logic [BUF_AW:0]   dump_size;
    logic              ovf;
    logic              changed;

    hiscore_dump_if bus();

    hiscore_dump #(
        .ENTRIES (16),
        .BUF_AW  (BUF_AW),
        .RAM_AW  (RAM_AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ioctl       (bus),
        .snap_req    (snap_req),
        .ram_address (ram_address),
        .ram_rd      (ram_rd),
        .ram_data    (ram_data),
        .busy        (busy),
        .snap_valid  (snap_valid),
        .dump_size   (dump_size),
        .ovf         (ovf),
        .changed     (changed)
    );

    // Game RAM model: one-cycle read latency.
    logic [7:0] ram [1024];
    always @(posedge clk) ram_data <= ram[ram_address];

    int checks = 0;
    int errors = 0;

    // Table as loaded into the DUT, and the model's history of captures.
    int unsigned tbl_base [16];
    int unsigned tbl_len  [16];
    int unsigned n_ent;
    logic [7:0]  prev_bytes [$];
    int unsigned prev_size;
    bit          first_cap;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_table();
        bus.ioctl_download = 1'b1;
        bus.ioctl_index    = 8'd3;
        for (int i = 0; i < int'(n_ent); i++) begin
            for (int b = 0; b < 8; b++) begin
                bus.ioctl_addr = 25'(i * 8 + b);
                case (b)
                    1:       bus.ioctl_dout = 8'(tbl_base[i] >> 16);
                    2:       bus.ioctl_dout = 8'(tbl_base[i] >> 8);
                    3:       bus.ioctl_dout = 8'(tbl_base[i]);
                    4:       bus.ioctl_dout = 8'(tbl_len[i]);
                    default: bus.ioctl_dout = 8'($urandom);
                endcase
                bus.ioctl_wr = 1'b1;
                tick();
                bus.ioctl_wr = 1'b0;
            end
        end
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_addr     = '0;
        tick();
    endtask

    task automatic capture(input string tag, input bit extra_req);
        logic [7:0]  exp_q [$];
        int unsigned exp_cycles;
        int unsigned exp_size;
        bit          exp_ovf;
        bit          exp_chg;
        int unsigned n;

        exp_cycles = 1;
        for (int i = 0; i < int'(n_ent); i++) begin
            exp_cycles += 1 + 2 * tbl_len[i];
            for (int unsigned k = 0; k < tbl_len[i]; k++)
                exp_q.push_back(ram[(tbl_base[i] + k) % 1024]);
        end
        exp_ovf  = exp_q.size() > CAP;
        exp_size = exp_ovf ? CAP : exp_q.size();
`ifdef HISCORE_DUMP_CHANGE_DETECT_EN
        exp_chg = first_cap || (exp_size != prev_size);
        if (!exp_chg)
            for (int unsigned a = 0; a < exp_size; a++)
                if (exp_q[a] != prev_bytes[a]) exp_chg = 1'b1;
`else
        exp_chg = 1'b1;
`endif

        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        check({tag, " busy_start"}, 32'(busy), 32'd1);
        n = 0;
        while (!snap_valid && n < 1000) begin
            snap_req = extra_req && (n == 3);
            tick();
            n++;
        end
        snap_req = 1'b0;
        check({tag, " cycles"}, n, exp_cycles);
        check({tag, " busy_end"}, 32'(busy), 32'd0);
        check({tag, " dump_size"}, 32'(dump_size), exp_size);
        check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
        check({tag, " changed"}, 32'(changed), 32'(exp_chg));
        if (extra_req) begin
            tick();
            check({tag, " req_not_queued"}, 32'(busy), 32'd0);
        end

        bus.ioctl_upload = 1'b1;
        for (int unsigned a = 0; a <= exp_size; a++) begin
            bus.ioctl_addr = 25'(a);
            tick();
            check({tag, " upload"}, 32'(bus.ioctl_din), (a < exp_size) ? 32'(exp_q[a]) : 32'd0);
        end
        bus.ioctl_upload = 1'b0;
        bus.ioctl_addr   = '0;
        tick();

        prev_bytes = exp_q;
        prev_size  = exp_size;
        first_cap  = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        snap_req           = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_upload   = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.ioctl_index    = '0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
        first_cap = 1'b1;
        prev_size = 0;

        repeat (3) tick();
        reset = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst snap_valid", 32'(snap_valid), 32'd0);
        check("rst ovf", 32'(ovf), 32'd0);
        check("rst changed", 32'(changed), 32'd0);
        check("rst ram_rd", 32'(ram_rd), 32'd0);
        check("rst dump_size", 32'(dump_size), 32'd0);
        check("rst din", 32'(bus.ioctl_din), 32'd0);
        check("rst ram_address", 32'(ram_address), 32'd0);

        // Request before any table is loaded.
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        check("req_no_table busy", 32'(busy), 32'd0);

        // Single entry at 0xB0, length 4.
        ram[10'hB0] = 8'h11; ram[10'hB1] = 8'h22;
        ram[10'hB2] = 8'h33; ram[10'hB3] = 8'h44;
        n_ent = 1; tbl_base[0] = 32'hB0; tbl_len[0] = 4;
        load_table();
        bus.ioctl_upload = 1'b1;
        bus.ioctl_addr   = '0;
        tick();
        check("upload_no_snap din", 32'(bus.ioctl_din), 32'd0);
        bus.ioctl_upload = 1'b0;
        capture("b0x4", 1'b0);
        capture("b0x4_again", 1'b0);
        ram[10'hB1] = 8'h5A;
        capture("b0x4_mod", 1'b0);

        // Two entries, one with a high base byte to exercise truncation.
        n_ent = 2;
        tbl_base[0] = 32'h000023; tbl_len[0] = 2;
        tbl_base[1] = 32'hAB0300; tbl_len[1] = 1;
        load_table();
        capture("two_ent", 1'b0);

        // Zero-length entry between two valid ones.
        n_ent = 3;
        tbl_base[0] = 32'h10;  tbl_len[0] = 3;
        tbl_base[1] = 32'h40;  tbl_len[1] = 0;
        tbl_base[2] = 32'h3FE; tbl_len[2] = 5;
        load_table();
        capture("zero_len", 1'b0);

        // Overflow, with a stray request while busy.
        n_ent = 1; tbl_base[0] = 32'h200; tbl_len[0] = 255;
        load_table();
        capture("ovf255", 1'b1);

        // Randomized tables.
        for (int r = 0; r < 6; r++) begin
            n_ent = $urandom_range(1, 4);
            for (int i = 0; i < int'(n_ent); i++) begin
                tbl_base[i] = $urandom & 32'hFFFFFF;
                tbl_len[i]  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 40);
            end
            for (int i = 0; i < 64; i++) ram[$urandom_range(0, 1023)] = 8'($urandom);
            load_table();
            capture("rand", 1'b0);
        end

        // Request during upload.
        bus.ioctl_upload = 1'b1;
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        check("req_upload busy", 32'(busy), 32'd0);
        bus.ioctl_upload = 1'b0;
        tick();

        // Reset in the middle of a capture.
        n_ent = 1; tbl_base[0] = 32'hB0; tbl_len[0] = 20;
        load_table();
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset busy", 32'(busy), 32'd0);
        check("mid_reset snap_valid", 32'(snap_valid), 32'd0);
        first_cap = 1'b1;
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        check("req_after_reset busy", 32'(busy), 32'd0);
        load_table();
        capture("after_reset", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
